out_port_uart_tx: RTL and testbench
===================================

// Module: out_port_uart_tx
// PURPOSE
//   Consumer end of the core's output-port interface (out_en/out_dat).
//   Buffers each 16-bit word the core writes in a FIFO and serialises it
//   on a UART TX line (8N1, LSB first): high byte first, then low byte.
//   Sits in the fst top next to core; the core never stalls, so words are
//   dropped when the FIFO is full and a sticky overflow flag is raised.
// PARAMETERS
//   CLKS_PER_BIT  434  clk cycles per UART bit (50 MHz / 115200 baud)
//   FIFO_DEPTH    16   words of buffering; power of 2, >= 2
// PORTS
//   clk        in   1   system clock; all state updates on rising edge
//   reset      in   1   asynchronous, active-high reset
//   out_en     in   1   core output strobe; one word per cycle it is high
//   out_dat    in   16  core output word, sampled when out_en=1
//   tx         out  1   UART serial line; idles high
//   busy       out  1   FIFO non-empty or frame in progress
//   full       out  1   FIFO holds FIFO_DEPTH words
//   overflow   out  1   sticky: a word was dropped since reset
//   fifo_count out  $clog2(FIFO_DEPTH)+1  words currently buffered
// BEHAVIOUR
//   Reset (async, any time, incl. mid-frame): tx=1, busy=0, full=0,
//     overflow=0, fifo_count=0, FSM=IDLE, FIFO emptied; frame aborted.
//   Push: out_en=1 && !full -> out_dat written at tail, count+1 next cycle.
//     out_en=1 && full -> word dropped, overflow<=1, held until reset;
//     a pop in the same cycle does not rescue it (full is the registered flag).
//   Simultaneous push+pop when not full: count unchanged, both take effect.
//   Pointers wrap modulo FIFO_DEPTH; full = (count==FIFO_DEPTH).
//   FSM states: IDLE, START, DATA, STOP; byte_sel (0=high,1=low); bit_idx 0..7;
//     baud counter 0..CLKS_PER_BIT-1; a bit ends when counter = CLKS_PER_BIT-1.
//   IDLE: tx=1; if count>0: pop head into shift word, byte_sel=0 -> START.
//   START: tx=0 for CLKS_PER_BIT cycles -> DATA, bit_idx=0.
//   DATA: tx=current byte[bit_idx] for CLKS_PER_BIT cycles each; after
//     bit 7 -> STOP.
//   STOP: tx=1 for CLKS_PER_BIT cycles; then byte_sel=0 -> byte_sel=1,
//     START (no idle gap); byte_sel=1 -> IDLE.
//   A word occupies exactly 20*CLKS_PER_BIT cycles on tx. IDLE to START
//     takes 1 cycle, so back-to-back words have a 1-cycle idle-high gap.
//   Latency: out_en high in cycle N with FIFO empty and FSM IDLE -> word
//     in FIFO at N+1 -> tx first low in cycle N+2.
//   tx is driven from a register (glitch-free).
//   busy = (FSM!=IDLE) || (count!=0); registered-equivalent, no comb
//     path from out_en.
//   Counters sized so CLKS_PER_BIT up to 65535 work without overflow.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4 unless noted)
//   1 Reset: assert reset mid-DATA -> tx=1, busy=0, count=0 immediately;
//     deassert -> tx stays 1 with no further strobes.
//   2 Single word: out_en 1 cycle, out_dat=16'hA55A -> tx low 2 cycles
//     later; decoded bytes 8'hA5 then 8'h5A; 80 cycles of framing; busy drops after.
//   3 Back-to-back: 3 consecutive strobes 16'h0001,16'h0203,16'h0405 ->
//     bytes 00 01 02 03 04 05 in order; 1-cycle gap between words; overflow=0.
//   4 Overflow: 6 consecutive strobes 16'h1111..16'h6666 while FIFO empty,
//     idle -> first popped at once, next 4 buffered, 6th dropped; overflow=1
//     stays set; output is 1111..5555.
//   5 Full+pop same cycle: fill to full, strobe in the exact cycle IDLE pops
//     -> word dropped, overflow=1, count goes 4->3.
//   6 Baud check: CLKS_PER_BIT=434 -> every tx bit lasts exactly 434 cycles.

Source files
------------

// File: rtl/out_port_uart_tx_if.sv
// Output-port bundle between the core (master) and the UART TX consumer (slave).
interface out_port_uart_tx_if #(
  parameter int unsigned FIFO_DEPTH = 16
) ();
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic            out_en;
  logic [15:0]     out_dat;
  logic            tx;
  logic            busy;
  logic            full;
  logic            overflow;
  logic [CntW-1:0] fifo_count;

  modport master (
    output out_en, out_dat,
    input  tx, busy, full, overflow, fifo_count
  );

  modport slave (
    input  out_en, out_dat,
    output tx, busy, full, overflow, fifo_count
  );
endinterface

// File: rtl/out_port_uart_tx.sv
// Buffers 16-bit core output words in a FIFO and sends each as two 8N1 UART bytes,
// high byte first. Words arriving while the FIFO is full are dropped and flagged.
module out_port_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input logic               clk,
  input logic               reset,
  out_port_uart_tx_if.slave bus
);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW     = AW + 1;
  localparam logic [15:0] BaudMax  = 16'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0] r_count, w_count_nxt;
  logic            r_overflow;

  state_e          r_state, w_state_nxt;
  logic [15:0]     r_shift;
  logic            r_byte_sel, w_byte_sel_nxt;
  logic [2:0]      r_bit_idx, w_bit_idx_nxt;
  logic [15:0]     r_baud, w_baud_nxt;
  logic            r_tx, w_tx_nxt;

  logic            w_full, w_push, w_pop, w_bit_end;
  logic [7:0]      w_byte;
  logic [2:0]      w_bit_idx_inc;

  // Full comes from the registered count, so a same-cycle pop cannot make room.
  assign w_full        = (r_count == CntFull);
  assign w_push        = bus.out_en && !w_full;
  assign w_bit_end     = (r_baud == BaudMax);
  assign w_byte        = r_byte_sel ? r_shift[7:0] : r_shift[15:8];
  assign w_bit_idx_inc = r_bit_idx + 3'd1;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CntW'(1);
      2'b01:   w_count_nxt = r_count - CntW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.out_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_shift    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        r_shift  <= r_mem[r_rd_ptr];
      end
      r_count <= w_count_nxt;
      if (bus.out_en && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= StIdle;
      r_byte_sel <= 1'b0;
      r_bit_idx  <= '0;
      r_baud     <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_byte_sel <= w_byte_sel_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_baud     <= w_baud_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  // tx is computed for the next state so the line comes straight from a flop.
  always_comb begin
    w_state_nxt    = r_state;
    w_byte_sel_nxt = r_byte_sel;
    w_bit_idx_nxt  = r_bit_idx;
    w_baud_nxt     = r_baud;
    w_tx_nxt       = r_tx;
    w_pop          = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_tx_nxt   = 1'b1;
        w_baud_nxt = '0;
        if (r_count != '0) begin
          w_pop          = 1'b1;
          w_byte_sel_nxt = 1'b0;
          w_state_nxt    = StStart;
          w_tx_nxt       = 1'b0;
        end
      end
      StStart: begin
        if (w_bit_end) begin
          w_baud_nxt    = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = StData;
          w_tx_nxt      = w_byte[0];
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      StData: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = StStop;
            w_tx_nxt    = 1'b1;
          end else begin
            w_bit_idx_nxt = w_bit_idx_inc;
            w_tx_nxt      = w_byte[w_bit_idx_inc];
          end
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      StStop: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (!r_byte_sel) begin
            w_byte_sel_nxt = 1'b1;
            w_state_nxt    = StStart;
            w_tx_nxt       = 1'b0;
          end else begin
            w_state_nxt = StIdle;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + 16'd1;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign bus.tx         = r_tx;
  assign bus.busy       = (r_state != StIdle) || (r_count != '0);
  assign bus.full       = w_full;
  assign bus.overflow   = r_overflow;
  assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_out_port_uart_tx.sv
// Directed bench: a UART decoder pops expected bytes from a scoreboard queue; a second
// instance at 434 clocks per bit checks bit timing.
module tb_out_port_uart_tx;
  localparam int unsigned CPB  = 4;
  localparam int unsigned CPB2 = 434;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  logic [7:0] exp_q[$];
  int         starts[$];

  out_port_uart_tx_if #(.FIFO_DEPTH(4)) if_a ();
  out_port_uart_tx_if #(.FIFO_DEPTH(4)) if_b ();

  out_port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  out_port_uart_tx #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Caller sits just after a falling edge; the word is sampled on the next rising edge.
  task automatic drive_word(input logic [15:0] d, input bit expect_out);
    if_a.out_en  = 1'b1;
    if_a.out_dat = d;
    if (expect_out) begin
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
    end
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      if (!if_a.busy) break;
      @(negedge clk);
    end
    check(tag, {31'd0, if_a.busy}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  // Decoder for instance A: start detected on its first low sample, bits sampled mid-cell.
  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (mon_en && if_a.tx === 1'b0) begin
        starts.push_back(cyc);
        repeat (CPB / 2) @(negedge clk);
        check("start_bit", {31'd0, if_a.tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = if_a.tx;
        end
        repeat (CPB) @(negedge clk);
        check("stop_bit", {31'd0, if_a.tx}, 32'd1);
        if (exp_q.size() == 0) begin
          e = 8'hxx;
        end else begin
          e = exp_q.pop_front();
        end
        check("rx_byte", {24'd0, b}, {24'd0, e});
      end
    end
  end

  initial begin : stim
    bit   saw_low;
    logic prev;
    int   n;
    if_a.out_en  = 1'b0;
    if_a.out_dat = '0;
    if_b.out_en  = 1'b0;
    if_b.out_dat = '0;

    // Reset state
    @(negedge clk);
    check("rst_tx", {31'd0, if_a.tx}, 32'd1);
    check("rst_busy", {31'd0, if_a.busy}, 32'd0);
    check("rst_count", {29'd0, if_a.fifo_count}, 32'd0);
    check("rst_full", {31'd0, if_a.full}, 32'd0);
    check("rst_ovf", {31'd0, if_a.overflow}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: reset mid-DATA aborts the frame immediately
    drive_word(16'h0000, 1'b0);
    if_a.out_en = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_busy", {31'd0, if_a.busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_tx", {31'd0, if_a.tx}, 32'd1);
    check("mid_rst_busy", {31'd0, if_a.busy}, 32'd0);
    check("mid_rst_count", {29'd0, if_a.fifo_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_low = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (if_a.tx !== 1'b1) saw_low = 1'b1;
    end
    check("post_rst_quiet", {31'd0, saw_low}, 32'd0);
    mon_en = 1'b1;

    // 2: single word latency and framing length
    drive_word(16'hA55A, 1'b1);
    if_a.out_en = 1'b0;
    check("w1_tx_n1", {31'd0, if_a.tx}, 32'd1);
    check("w1_count", {29'd0, if_a.fifo_count}, 32'd1);
    check("w1_busy", {31'd0, if_a.busy}, 32'd1);
    @(negedge clk);
    check("w1_tx_n2", {31'd0, if_a.tx}, 32'd0);
    repeat (79) @(negedge clk);
    check("w1_busy_end", {31'd0, if_a.busy}, 32'd1);
    @(negedge clk);
    check("w1_idle", {31'd0, if_a.busy}, 32'd0);
    check("w1_tx_idle", {31'd0, if_a.tx}, 32'd1);
    repeat (4) @(negedge clk);

    // 3: back-to-back words, 1-cycle gap between words
    starts.delete();
    drive_word(16'h0001, 1'b1);
    drive_word(16'h0203, 1'b1);
    drive_word(16'h0405, 1'b1);
    if_a.out_en = 1'b0;
    wait_idle("b2b_idle");
    check("b2b_nstarts", starts.size(), 32'd6);
    if (starts.size() == 6) begin
      check("b2b_byte_gap", starts[1] - starts[0], 32'd40);
      check("b2b_word_gap1", starts[2] - starts[0], 32'd81);
      check("b2b_word_gap2", starts[4] - starts[2], 32'd81);
    end
    check("b2b_ovf", {31'd0, if_a.overflow}, 32'd0);

    // 4: overflow on the sixth back-to-back strobe
    drive_word(16'h1111, 1'b1);
    drive_word(16'h2222, 1'b1);
    drive_word(16'h3333, 1'b1);
    drive_word(16'h4444, 1'b1);
    drive_word(16'h5555, 1'b1);
    drive_word(16'h6666, 1'b0);
    if_a.out_en = 1'b0;
    check("ovf_full", {31'd0, if_a.full}, 32'd1);
    check("ovf_count", {29'd0, if_a.fifo_count}, 32'd4);
    check("ovf_flag", {31'd0, if_a.overflow}, 32'd1);
    wait_idle("ovf_idle");
    check("ovf_sticky", {31'd0, if_a.overflow}, 32'd1);
    check("ovf_q_empty", exp_q.size(), 32'd0);

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst2_ovf", {31'd0, if_a.overflow}, 32'd0);

    // 5: strobe into a full FIFO on the exact cycle IDLE pops
    drive_word(16'hC000, 1'b1);
    drive_word(16'hC111, 1'b1);
    drive_word(16'hC222, 1'b1);
    drive_word(16'hC333, 1'b1);
    drive_word(16'hC444, 1'b1);
    if_a.out_en = 1'b0;
    repeat (77) @(negedge clk);
    check("fp_full_before", {31'd0, if_a.full}, 32'd1);
    check("fp_count_before", {29'd0, if_a.fifo_count}, 32'd4);
    check("fp_ovf_before", {31'd0, if_a.overflow}, 32'd0);
    drive_word(16'hBEEF, 1'b0);
    if_a.out_en = 1'b0;
    check("fp_count_after", {29'd0, if_a.fifo_count}, 32'd3);
    check("fp_ovf_after", {31'd0, if_a.overflow}, 32'd1);
    check("fp_full_after", {31'd0, if_a.full}, 32'd0);
    wait_idle("fp_idle");
    check("fp_q_empty", exp_q.size(), 32'd0);

    // 6: bit timing at 434 clocks per bit; 0x55 toggles on every bit boundary
    if_b.out_en  = 1'b1;
    if_b.out_dat = 16'h5555;
    @(negedge clk);
    if_b.out_en = 1'b0;
    n = 0;
    while (if_b.tx !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("baud_start", {31'd0, if_b.tx}, 32'd0);
    for (int j = 0; j < 19; j++) begin
      prev = if_b.tx;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (if_b.tx === prev && n < 1000);
      check("baud_bit_len", n, CPB2);
    end
    repeat (CPB2 - 1) @(negedge clk);
    check("baud_busy_end", {31'd0, if_b.busy}, 32'd1);
    @(negedge clk);
    check("baud_idle", {31'd0, if_b.busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
